// File: rtl/stream_take_sum_pkg.sv
// Shared definitions for stream_take_sum: default int width, FSM state encoding and
// the call/result bundle types used by the block and its adder.
package stream_take_sum_pkg;

  // Default width of ints and stream data in generated blocks.
  localparam int unsigned IntWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Call token as seen on the in_valid/in_ready handshake.
  typedef struct packed {
    logic                valid;
    logic [IntWidth-1:0] count;
  } call_t;

  // Result as presented on the out_valid/out_ready handshake.
  typedef struct packed {
    logic                valid;
    logic [IntWidth-1:0] data;
  } result_t;

  // True when a signed count requests no beats at all.
  function automatic logic count_is_empty(input logic signed [IntWidth-1:0] count);
    return count <= 0;
  endfunction

endpackage

// File: rtl/stream_take_sum_add.sv
// Combinational signed adder for the stream_take_sum accumulator.
// Wraps modulo 2^Width unless STREAM_TAKE_SUM_SATURATE_EN is defined, in which case it clamps.
module stream_take_sum_add
  import stream_take_sum_pkg::*;
#(
  parameter int unsigned Width = IntWidth
) (
  input  logic signed [Width-1:0] a,
  input  logic signed [Width-1:0] b,
  output logic signed [Width-1:0] sum
);

  // One guard bit exposes signed overflow as a mismatch of the two top bits.
  logic signed [Width:0] wide;

  assign wide = {a[Width-1], a} + {b[Width-1], b};

`ifdef STREAM_TAKE_SUM_SATURATE_EN
  logic overflow;

  assign overflow = wide[Width] ^ wide[Width-1];

  always_comb begin
    sum = wide[Width-1:0];
    if (overflow) begin
      // Sign of the true result selects which rail to clamp to.
      sum = wide[Width] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    end
  end
`else
  logic unused_guard;

  assign unused_guard = wide[Width];
  assign sum          = wide[Width-1:0];
`endif

endmodule

// File: rtl/stream_take_sum.sv
// Stream reducer: accepts a call with a signed beat count, pops that many beats and sums them.
// Build option STREAM_TAKE_SUM_SATURATE_EN selects saturating instead of wrapping addition.
module stream_take_sum
  import stream_take_sum_pkg::*;
#(
  parameter int unsigned WIDTH = IntWidth
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] dCount,
  input  logic signed [WIDTH-1:0] sIn,
  input  logic                    sIn_valid,
  output logic                    sIn_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] dOut
);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] remaining_q, remaining_d;
  logic signed [WIDTH-1:0] dout_q, dout_d;
  logic signed [WIDTH-1:0] sum;
  logic                    beat;
  logic                    last_beat;
  logic                    empty_call;

  stream_take_sum_add #(
    .Width(WIDTH)
  ) u_add (
    .a  (acc_q),
    .b  (sIn),
    .sum(sum)
  );

  assign beat       = sIn_valid & sIn_ready;
  assign last_beat  = remaining_q == WIDTH'(1);
  assign empty_call = dCount <= 0;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    dout_d      = dout_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          remaining_d = dCount;
          acc_d       = '0;
          if (empty_call) begin
            dout_d  = '0;
            state_d = StDone;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (beat) begin
          acc_d       = sum;
          remaining_d = remaining_q - WIDTH'(1);
          if (last_beat) begin
            dout_d  = sum;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      remaining_q <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      dout_q      <= dout_d;
    end
  end

  // Handshake outputs depend only on registered state.
  assign in_ready  = state_q == StIdle;
  assign sIn_ready = state_q == StAccum;
  assign out_valid = state_q == StDone;
  assign dOut      = dout_q;

endmodule

// File: tb/tb_stream_take_sum.sv
// Scoreboard bench for stream_take_sum: directed calls push expected sums, a monitor pops them.
module tb_stream_take_sum;

  logic              clk = 1'b0;
  logic              nrst;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] dCount;
  logic signed [7:0] sIn;
  logic              sIn_valid;
  logic              sIn_ready;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] dOut;

  int          tests = 0;
  int          fails = 0;
  int          beats = 0;
  int          base;
  logic [7:0]  exp_q[$];
  logic [7:0]  wrap_exp;

  stream_take_sum #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dCount   (dCount),
    .sIn      (sIn),
    .sIn_valid(sIn_valid),
    .sIn_ready(sIn_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dOut     (dOut)
  );

  always #5 clk = ~clk;

  // Beats actually popped by the DUT, as the producer would see them.
  always @(posedge clk) if (nrst && sIn_valid && sIn_ready) beats <= beats + 1;

  // Monitor: every completed result handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (nrst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL result_unexpected: got dOut=%0d, required no result", dOut);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dOut !== e) begin
          fails++;
          $display("FAIL result_value: got dOut=%0d, required %0d", dOut, $signed(e));
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && in_ready !== 1'b1; i++) tick();
    check(name, 32'(in_ready), 32'd1);
  endtask

  initial begin
    nrst      = 1'b0;
    in_valid  = 1'b1;
    dCount    = 8'sd3;
    sIn       = 8'sd11;
    sIn_valid = 1'b1;
    out_ready = 1'b1;

    // Reset held two cycles while a call is offered.
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sin_ready", 32'(sIn_ready), 32'd0);
    check("rst_dout", 32'(dOut), 32'd0);
    in_valid  = 1'b0;
    sIn_valid = 1'b0;
    out_ready = 1'b0;
    nrst      = 1'b1;
    tick();
    check("rst_no_call", 32'(in_ready), 32'd1);

    // Repeat-42 producer, count 3.
    exp_q.push_back(8'd126);
    base      = beats;
    in_valid  = 1'b1;
    dCount    = 8'sd3;
    sIn       = 8'sd42;
    sIn_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rep_sin_ready", 32'(sIn_ready), 32'd1);
    tick();
    tick();
    check("rep_not_done", 32'(out_valid), 32'd0);
    tick();
    check("rep_out_valid", 32'(out_valid), 32'd1);
    check("rep_beats", 32'(beats - base), 32'd3);
    check("rep_sin_ready_off", 32'(sIn_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rep_idle", 32'(in_ready), 32'd1);
    check("rep_beats_after", 32'(beats - base), 32'd3);
    sIn_valid = 1'b0;

    // Overflowing sum: 4 x 100.
`ifdef STREAM_TAKE_SUM_SATURATE_EN
    wrap_exp = 8'd127;
`else
    wrap_exp = 8'd144;
`endif
    exp_q.push_back(wrap_exp);
    base      = beats;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dCount    = 8'sd4;
    sIn       = 8'sd100;
    sIn_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("wrap_out_valid", 32'(out_valid), 32'd1);
    check("wrap_beats", 32'(beats - base), 32'd4);
    tick();
    sIn_valid = 1'b0;
    wait_idle("wrap_idle", 10);

    // Zero and negative counts with a live stream.
    sIn       = 8'sd55;
    sIn_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(8'd0);
      base     = beats;
      in_valid = 1'b1;
      dCount   = (k == 0) ? 8'sd0 : -8'sd5;
      tick();
      in_valid = 1'b0;
      check("empty_out_valid", 32'(out_valid), 32'd1);
      tick();
      check("empty_beats", 32'(beats - base), 32'd0);
      check("empty_idle", 32'(in_ready), 32'd1);
    end
    sIn_valid = 1'b0;

    // Stream gap plus result backpressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    dCount    = 8'sd2;
    tick();
    in_valid  = 1'b0;
    sIn       = 8'sd7;
    sIn_valid = 1'b1;
    tick();
    sIn_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("stall_sin_ready", 32'(sIn_ready), 32'd1);
    check("stall_out_valid", 32'(out_valid), 32'd0);
    sIn       = -8'sd3;
    sIn_valid = 1'b1;
    tick();
    sIn_valid = 1'b0;
    check("stall_dout", 32'(dOut), 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_dout", 32'(dOut), 32'd4);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    exp_q.push_back(8'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Reset after two of five beats, then a fresh single-beat call.
    in_valid  = 1'b1;
    dCount    = 8'sd5;
    sIn       = 8'sd1;
    sIn_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    sIn_valid = 1'b0;
    nrst      = 1'b0;
    tick();
    nrst = 1'b1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_sin_ready", 32'(sIn_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(8'd9);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dCount    = 8'sd1;
    tick();
    in_valid  = 1'b0;
    sIn       = 8'sd9;
    sIn_valid = 1'b1;
    tick();
    sIn_valid = 1'b0;
    check("midrst_done", 32'(out_valid), 32'd1);
    wait_idle("midrst_idle", 10);

    // Largest legal count.
    exp_q.push_back(8'd127);
    base      = beats;
    in_valid  = 1'b1;
    dCount    = 8'sd127;
    sIn       = 8'sd1;
    sIn_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 127; i++) tick();
    check("max_out_valid", 32'(out_valid), 32'd1);
    check("max_beats", 32'(beats - base), 32'd127);
    sIn_valid = 1'b0;
    wait_idle("max_idle", 10);

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_take_sum.md
Name: stream_take_sum

Overview:
- Stream consumer that sits directly downstream of a stream-producing function block, such as a compiled repeat.
- Accepts a call token carrying a signed element count `dCount`.
- Pops exactly `dCount` beats from an input stream and sums them.
- Returns the sum as a single int result through the standard sync output handshake. It reduces a stream to a scalar, so the generated design can close a stream pipeline.

Parameters:
- WIDTH, 8, bit width of ints and stream data (matches the codebase default int width).

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- in_valid  in  1  call token valid.
- in_ready  out  1  block can accept a call.
- dCount  in  WIDTH  signed number of stream beats to consume; sampled on call accept.
- sIn  in  WIDTH  stream data beat, signed.
- sIn_valid  in  1  stream beat valid.
- sIn_ready  out  1  block consumes a beat this cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- dOut  out  WIDTH  signed sum.

Behaviour:
- Interface fixed: single clock `clk`; reset `nrst` is synchronous and active-low, sampled only on the clk rising edge.
- Reset values (nrst low at an edge):
  - state = IDLE, acc = 0, remaining = 0.
  - dOut = 0, out_valid = 0, sIn_ready = 0, in_ready = 1.
- Output decode:
  - in_ready = (state == IDLE).
  - sIn_ready = (state == ACCUM).
  - out_valid = (state == DONE).
  - All are decoded from registered state; there is no combinational in-to-out path.
- IDLE:
  - On in_valid & in_ready: latch remaining = dCount; acc = 0.
  - If dCount <= 0 (signed): dOut = 0 and next state DONE. No stream beats are consumed.
  - Otherwise next state ACCUM.
- ACCUM:
  - On each sIn_valid & sIn_ready: acc = acc + sIn, remaining = remaining - 1.
  - The beat that brings remaining to 0 also loads dOut = acc + sIn, and next state is DONE.
  - Cycles with sIn_valid = 0 are stalls: no state change.
- DONE:
  - dOut and out_valid are held stable until out_ready.
  - On out_valid & out_ready: next state IDLE, so a new call can be accepted the following cycle.
- Arithmetic: two's complement, width WIDTH, wraps modulo 2^WIDTH by default.
- Latency:
  - Result is valid the cycle after the last beat is accepted.
  - For count 0 or negative, result is valid the cycle after the call is accepted.
  - With continuous stream valid: n beats take n cycles. Throughput is one call per n+2 cycles.
- Boundaries:
  - Beats presented in IDLE or DONE are not consumed (sIn_ready = 0). The stream producer stalls and no beats are dropped.
  - in_valid held high during ACCUM/DONE is ignored until IDLE.
  - out_ready asserted before DONE has no effect.
  - Reset mid-ACCUM abandons the partial sum. Beats not yet popped remain with the producer.
  - A count of 2^(WIDTH-1) - 1 is legal.

Optional Feature:
- Macro STREAM_TAKE_SUM_SATURATE_EN.
- Defined: each addition saturates to the range [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Once clamped, acc continues saturating arithmetic from the clamped value.
- Undefined: plain wrapping addition, as described above.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package/header holds:
  - state encoding constants IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
  - the int width macro;
  - the sync/in/out port-bundle macros already used for generated blocks.
- One natural sub-module: stream_take_sum_add. It is a combinational WIDTH-bit signed adder that contains the saturate/wrap selection under the macro, and it is instantiated once in the top.

Test Plan:
- Reset: hold nrst low 2 cycles with in_valid = 1 → in_ready = 1, out_valid = 0, sIn_ready = 0, dOut = 0. No call is accepted while reset is low.
- Upstream pairing: connect a repeat-42 stream producer and call dCount = 3 → exactly 3 beats popped, dOut = 126, out_valid one cycle after the 3rd beat. The producer sees sIn_ready = 0 afterwards.
- Wrap: dCount = 4, beats all 100 → dOut = 144 (400 mod 256) without the macro; dOut = 127 with STREAM_TAKE_SUM_SATURATE_EN.
- Zero/negative: dCount = 0, then dCount = -5, with sIn_valid = 1 → dOut = 0 each time and zero beats consumed. out_valid rises the cycle after accept.
- Stalls/backpressure: dCount = 2, beats 7 and -3 with a 3-cycle sIn_valid gap between them, out_ready low for 4 cycles → dOut = 4 held stable throughout. in_ready stays 0 until the cycle after out_ready.
- Reset mid-op: dCount = 5, reset after 2 beats, then a new call dCount = 1 with beat 9 → dOut = 9 (no residue from the abandoned sum).
